pc_select_predictor: RTL and testbench

Next-generation PC input selector for the fetch/decode stage. It replaces the purely combinational opcode/branch_result select with a parametrised branch history table (BHT) of 2-bit saturating counters. It predicts pc_input_sel at fetch time, trains on resolved branches from execute, and flags mispredicts so the pipeline can redirect. It sits between fetch PC generation and the PC input mux, and uses instructions_pkg opcode_t and pc_input_sel_t.

---
 rtl/pc_select_predictor.sv | 118 +++++++++++
 tb/tb_pc_select_predictor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_select_predictor.sv
// pc_select_predictor: fetch-time PC input select driven by a branch history
// table of 2-bit saturating counters. Trained from resolved branches in execute;
// raises a registered mispredict pulse and keeps a saturating mispredict count.
module pc_select_predictor #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BHT_ENTRIES  = 64,
    parameter int unsigned IDX_LSB      = 2,
    parameter logic [1:0]  COUNTER_INIT = 2'b01,
    parameter int unsigned STAT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_valid,
    input  logic [XLEN-1:0]       fetch_pc,
    input  logic [6:0]            fetch_opcode,
    output logic                  pc_input_sel,
    output logic                  predict_taken,
    input  logic                  resolve_valid,
    input  logic [XLEN-1:0]       resolve_pc,
    input  logic [6:0]            resolve_opcode,
    input  logic                  resolve_taken,
    input  logic                  resolve_predicted,
    output logic                  mispredict,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int unsigned IDX_W = (BHT_ENTRIES > 2) ? $clog2(BHT_ENTRIES) : 1;

    // opcode_t / pc_input_sel_t encodings shared with instructions_pkg
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    localparam logic PC_INPUT_PC_PLUS_4 = 1'b0;
    localparam logic PC_INPUT_ALU       = 1'b1;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0]            bht [BHT_ENTRIES];
    logic [IDX_W-1:0]      fetch_idx;
    logic [IDX_W-1:0]      resolve_idx;
    logic                  train_p0;
    logic                  mispredict_p0;
    logic                  mispredict_p1;
    logic [STAT_WIDTH-1:0] mispredict_count_p2;
    logic                  unused_pc_bits;

    // Upper and sub-word PC bits play no part in indexing; aliasing is intended.
    assign unused_pc_bits = ^{fetch_pc, resolve_pc};

    assign fetch_idx   = fetch_pc[IDX_LSB +: IDX_W];
    assign resolve_idx = resolve_pc[IDX_LSB +: IDX_W];

    // ---- stage p0: resolve inputs qualified for training and mispredict ----
    assign train_p0      = resolve_valid && (resolve_opcode == OPCODE_BRANCH);
    assign mispredict_p0 = train_p0 && (resolve_taken != resolve_predicted);

    // Fetch-side select: combinational read of the pre-update counter, no bypass.
    always_comb begin
        pc_input_sel  = PC_INPUT_PC_PLUS_4;
        predict_taken = 1'b0;
        if (reset) begin
            predict_taken = bht[fetch_idx][1];
            if (fetch_valid) begin
                case (fetch_opcode)
                    OPCODE_JAL, OPCODE_JALR: pc_input_sel = PC_INPUT_ALU;
                    OPCODE_BRANCH:           pc_input_sel = bht[fetch_idx][1] ? PC_INPUT_ALU
                                                                              : PC_INPUT_PC_PLUS_4;
                    default:                 pc_input_sel = PC_INPUT_PC_PLUS_4;
                endcase
            end
        end
    end

    // BHT training: saturating counter update on resolved conditional branches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht[i] <= COUNTER_INIT;
            end
        end else if (train_p0) begin
            bht[resolve_idx] <= resolve_taken ? ctr_inc(bht[resolve_idx])
                                              : ctr_dec(bht[resolve_idx]);
        end
    end

    // ---- stage p1: registered one-cycle mispredict pulse ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispredict_p1 <= 1'b0;
        end else begin
            mispredict_p1 <= mispredict_p0;
        end
    end

    // ---- stage p2: saturating mispredict statistic ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispredict_count_p2 <= '0;
        end else if (mispredict_p1) begin
            mispredict_count_p2 <= stat_inc(mispredict_count_p2);
        end
    end

    assign mispredict       = mispredict_p1;
    assign mispredict_count = mispredict_count_p2;

endmodule

// File: tb/tb_pc_select_predictor.sv
// tb_pc_select_predictor: directed stimulus with a mispredict scoreboard and a
// small BHT / statistic reference model.
module tb_pc_select_predictor;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic SEL_PC4 = 1'b0;
    localparam logic SEL_ALU = 1'b1;

    logic        clk;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [6:0]  fetch_opcode;
    logic        pc_input_sel;
    logic        predict_taken;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic [6:0]  resolve_opcode;
    logic        resolve_taken;
    logic        resolve_predicted;
    logic        mispredict;
    logic [15:0] mispredict_count;

    pc_select_predictor dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_opcode      (fetch_opcode),
        .pc_input_sel      (pc_input_sel),
        .predict_taken     (predict_taken),
        .resolve_valid     (resolve_valid),
        .resolve_pc        (resolve_pc),
        .resolve_opcode    (resolve_opcode),
        .resolve_taken     (resolve_taken),
        .resolve_predicted (resolve_predicted),
        .mispredict        (mispredict),
        .mispredict_count  (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]  m_bht [64];
    logic [15:0] m_cnt;
    logic        m_mp;
    logic        exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        m_cnt = 16'd0;
        m_mp  = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check fetch outputs, then check the
    // registered outputs just after the rising edge.
    task automatic cycle(input logic rst_v,
                         input logic fv, input logic [31:0] fpc, input logic [6:0] fop,
                         input logic rv, input logic [31:0] rpc, input logic [6:0] rop,
                         input logic rt, input logic rp);
        logic       e_sel;
        logic       e_pt;
        logic       e_mp;
        logic       got;
        logic [5:0] fi;
        logic [5:0] ri;
        @(negedge clk);
        reset = rst_v; fetch_valid = fv; fetch_pc = fpc; fetch_opcode = fop;
        resolve_valid = rv; resolve_pc = rpc; resolve_opcode = rop;
        resolve_taken = rt; resolve_predicted = rp;
        if (!rst_v) model_reset();
        fi = fpc[7:2];
        ri = rpc[7:2];
        #1;
        e_pt  = rst_v ? m_bht[fi][1] : 1'b0;
        e_sel = SEL_PC4;
        if (rst_v && fv) begin
            if (fop == OP_JAL || fop == OP_JALR) e_sel = SEL_ALU;
            else if (fop == OP_BRANCH)           e_sel = m_bht[fi][1];
        end
        chk("pc_input_sel", {31'd0, pc_input_sel}, {31'd0, e_sel});
        chk("predict_taken", {31'd0, predict_taken}, {31'd0, e_pt});
        e_mp = rst_v && rv && (rop == OP_BRANCH) && (rt != rp);
        exp_q.push_back(e_mp);
        @(posedge clk);
        if (rst_v) begin
            if (m_mp && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_mp = e_mp;
            if (rv && rop == OP_BRANCH) begin
                if (rt && m_bht[ri] != 2'b11)       m_bht[ri] = m_bht[ri] + 2'b01;
                else if (!rt && m_bht[ri] != 2'b00) m_bht[ri] = m_bht[ri] - 2'b01;
            end
        end
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            chk("mispredict", {31'd0, mispredict}, {31'd0, got});
        end
        chk("mispredict_count", {16'd0, mispredict_count}, {16'd0, m_cnt});
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [6:0] op);
        cycle(1'b1, 1'b1, pc, op, 1'b0, 32'd0, OP_IMM, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [6:0] op,
                           input logic t, input logic p);
        cycle(1'b1, 1'b0, 32'd0, OP_IMM, 1'b1, pc, op, t, p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; fetch_opcode = OP_IMM;
        resolve_valid = 1'b0; resolve_pc = '0; resolve_opcode = OP_IMM;
        resolve_taken = 1'b0; resolve_predicted = 1'b0;
        model_reset();

        // Reset held: fetch forced to PC+4, in-flight resolve discarded
        cycle(1'b0, 1'b1, 32'h40, OP_BRANCH, 1'b1, 32'h40, OP_BRANCH, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 32'h40, OP_JAL,    1'b1, 32'h40, OP_BRANCH, 1'b1, 1'b0);
        fetch(32'h40, OP_BRANCH);
        chk("reset_pt_idx16", {31'd0, predict_taken}, 32'd0);
        chk("reset_count", {16'd0, mispredict_count}, 32'd0);

        // Training 01 -> 10 -> 11 with two mispredicts
        resolve(32'h40, OP_BRANCH, 1'b1, 1'b0);
        resolve(32'h40, OP_BRANCH, 1'b1, 1'b0);
        fetch(32'h40, OP_BRANCH);
        chk("train_sel_alu", {31'd0, pc_input_sel}, {31'd0, SEL_ALU});
        chk("train_count2", {16'd0, mispredict_count}, 32'd2);

        // Saturation at 11, then walk down
        for (int i = 0; i < 5; i++) resolve(32'h40, OP_BRANCH, 1'b1, 1'b1);
        fetch(32'h40, OP_BRANCH);
        resolve(32'h40, OP_BRANCH, 1'b0, 1'b1);
        fetch(32'h40, OP_BRANCH);
        chk("sat_10_alu", {31'd0, pc_input_sel}, {31'd0, SEL_ALU});
        resolve(32'h40, OP_BRANCH, 1'b0, 1'b1);
        fetch(32'h40, OP_BRANCH);
        chk("sat_01_pc4", {31'd0, pc_input_sel}, {31'd0, SEL_PC4});

        // Aliasing and no-bypass
        resolve(32'h40, OP_BRANCH, 1'b1, 1'b0);
        resolve(32'h40, OP_BRANCH, 1'b1, 1'b0);
        fetch(32'h140, OP_BRANCH);
        chk("alias_140_alu", {31'd0, pc_input_sel}, {31'd0, SEL_ALU});
        cycle(1'b1, 1'b1, 32'h40, OP_BRANCH, 1'b1, 32'h140, OP_BRANCH, 1'b0, 1'b1);
        fetch(32'h40, OP_BRANCH);
        chk("bypass_next_10", {31'd0, pc_input_sel}, {31'd0, SEL_ALU});

        // Jumps and defaults with counter driven to 00
        resolve(32'h40, OP_BRANCH, 1'b0, 1'b0);
        resolve(32'h40, OP_BRANCH, 1'b0, 1'b0);
        fetch(32'h40, OP_JAL);
        fetch(32'h40, OP_JALR);
        fetch(32'h40, OP_IMM);
        cycle(1'b1, 1'b0, 32'h40, OP_JAL, 1'b0, 32'd0, OP_IMM, 1'b0, 1'b0);
        resolve(32'h40, OP_JAL, 1'b0, 1'b1);
        resolve(32'h44, OP_JALR, 1'b0, 1'b1);
        resolve(32'h40, OP_IMM, 1'b1, 1'b0);
        fetch(32'h40, OP_BRANCH);
        chk("jal_no_train", {31'd0, predict_taken}, 32'd0);

        // Mid-operation reset during a mispredicting resolve
        resolve(32'h40, OP_BRANCH, 1'b1, 1'b1);
        resolve(32'h40, OP_BRANCH, 1'b1, 1'b1);
        fetch(32'h40, OP_BRANCH);
        cycle(1'b0, 1'b1, 32'h40, OP_BRANCH, 1'b1, 32'h40, OP_BRANCH, 1'b1, 1'b0);
        chk("midreset_mp", {31'd0, mispredict}, 32'd0);
        fetch(32'h40, OP_BRANCH);
        chk("midreset_ctr01", {31'd0, predict_taken}, 32'd0);
        chk("midreset_count", {16'd0, mispredict_count}, 32'd0);

        // Statistic saturation at 0xFFFF
        force dut.mispredict_count_p2 = 16'hFFFF;
        m_cnt = 16'hFFFF;
        resolve(32'h48, OP_BRANCH, 1'b1, 1'b0);
        release dut.mispredict_count_p2;
        resolve(32'h48, OP_BRANCH, 1'b1, 1'b0);
        fetch(32'h48, OP_BRANCH);
        fetch(32'h48, OP_BRANCH);
        chk("count_saturated", {16'd0, mispredict_count}, 32'h0000FFFF);

        if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
